// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game: sequence depth, LFSR constants,
// generator state encoding and the colour code type.
package genius_pkg;

    localparam int unsigned SEQ_DEPTH    = 16;
    localparam int unsigned IDX_W        = $clog2(SEQ_DEPTH);
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StReady
    } gen_state_e;

    typedef logic [1:0] colour_t;

endpackage

// File: rtl/genius_sequence_gen_if.sv
// Link between the sequence generator and the game FSM / start switch.
interface genius_sequence_gen_if;
    import genius_pkg::*;

    logic                 start;
    logic [IDX_W-1:0]     sequence_count;
    colour_t              current_number;
    logic                 ready;

    modport master (
        output start,
        output sequence_count,
        input  current_number,
        input  ready
    );

    modport slave (
        input  start,
        input  sequence_count,
        output current_number,
        output ready
    );

endinterface

// File: rtl/genius_lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous load; resets to the default seed.
module genius_lfsr16 #(
    parameter logic [15:0] LFSR_TAPS    = genius_pkg::LFSR_TAPS,
    parameter logic [15:0] DEFAULT_SEED = genius_pkg::DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] lfsr,
    output logic [15:0] lfsr_next
);

    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign lfsr      = lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = lfsr_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/genius_sequence_gen.sv
// Genius colour-sequence source: on each new-game start edge, seeds the LFSR and
// fills a fixed colour table that the game FSM then reads back level by level.
module genius_sequence_gen #(
    parameter int unsigned SEQ_DEPTH    = genius_pkg::SEQ_DEPTH,
    parameter logic [15:0] LFSR_TAPS    = genius_pkg::LFSR_TAPS,
    parameter logic [15:0] DEFAULT_SEED = genius_pkg::DEFAULT_SEED,
    parameter bit          FIXED_SEED   = 1'b0
) (
    input logic                  clock,
    input logic                  reset,
    genius_sequence_gen_if.slave bus
);
    import genius_pkg::*;

    localparam int unsigned IdxW = $clog2(SEQ_DEPTH);

    logic            sync1_q, sync2_q, sync_prev_q, go_q;
    logic [15:0]     free_cnt_q;
    gen_state_e      state_q, state_d;
    logic [IdxW-1:0] fill_idx_q, fill_idx_d;
    colour_t         mem_q [SEQ_DEPTH];
    colour_t         current_number_q, current_number_d;

    logic            lfsr_load, lfsr_step, mem_we;
    logic [15:0]     seed_raw, seed, lfsr, lfsr_next;

    // A zero seed would lock the LFSR at zero forever.
    assign seed_raw = FIXED_SEED ? DEFAULT_SEED : free_cnt_q;
    assign seed     = (seed_raw == 16'h0000) ? DEFAULT_SEED : seed_raw;

    genius_lfsr16 #(
        .LFSR_TAPS   (LFSR_TAPS),
        .DEFAULT_SEED(DEFAULT_SEED)
    ) u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .load     (lfsr_load),
        .seed     (seed),
        .step     (lfsr_step),
        .lfsr     (lfsr),
        .lfsr_next(lfsr_next)
    );

    logic unused_lfsr;
    assign unused_lfsr = ^{lfsr, lfsr_next[15:2]};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q          <= 1'b0;
            sync2_q          <= 1'b0;
            sync_prev_q      <= 1'b0;
            go_q             <= 1'b0;
            free_cnt_q       <= 16'h0000;
            state_q          <= StIdle;
            fill_idx_q       <= '0;
            current_number_q <= '0;
        end else begin
            sync1_q          <= bus.start;
            sync2_q          <= sync1_q;
            sync_prev_q      <= sync2_q;
            go_q             <= sync2_q & ~sync_prev_q;
            free_cnt_q       <= free_cnt_q + 16'd1;
            state_q          <= state_d;
            fill_idx_q       <= fill_idx_d;
            current_number_q <= current_number_d;
        end
    end

    // Table has no reset; it is only exposed once a full fill has completed.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[fill_idx_q] <= lfsr_next[1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_idx_d = fill_idx_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        mem_we     = 1'b0;
        if (go_q) begin
            state_d    = StFill;
            fill_idx_d = '0;
            lfsr_load  = 1'b1;
        end else begin
            case (state_q)
                StIdle:  ;
                StFill: begin
                    lfsr_step  = 1'b1;
                    mem_we     = 1'b1;
                    fill_idx_d = fill_idx_q + 1'b1;
                    if (fill_idx_q == IdxW'(SEQ_DEPTH - 1)) begin
                        state_d = StReady;
                    end
                end
                StReady: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Blank the output already in the go cycle so it reads 0 while ready is low.
    always_comb begin
        current_number_d = '0;
        if (state_q == StReady && !go_q) begin
            current_number_d = mem_q[bus.sequence_count];
        end
    end

    assign bus.current_number = current_number_q;
    assign bus.ready          = (state_q == StReady);

endmodule

// File: tb/tb_genius_sequence_gen.sv
// Directed bench for genius_sequence_gen: a fixed-seed and a free-running-seed instance.
module tb_genius_sequence_gen;
    import genius_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_fix, rst_rnd, start_fix, start_rnd, sel;
    logic [3:0] seq;
    logic       ready_s;
    logic [1:0] cn_s;

    genius_sequence_gen_if bus_fix ();
    genius_sequence_gen_if bus_rnd ();

    assign bus_fix.start          = start_fix;
    assign bus_rnd.start          = start_rnd;
    assign bus_fix.sequence_count = seq;
    assign bus_rnd.sequence_count = seq;
    assign ready_s = sel ? bus_rnd.ready : bus_fix.ready;
    assign cn_s    = sel ? bus_rnd.current_number : bus_fix.current_number;

    genius_sequence_gen #(.FIXED_SEED(1'b1)) dut_fix (
        .clock(clk),
        .reset(rst_fix),
        .bus  (bus_fix)
    );

    genius_sequence_gen #(.FIXED_SEED(1'b0)) dut_rnd (
        .clock(clk),
        .reset(rst_rnd),
        .bus  (bus_rnd)
    );

    // Edges since rst_rnd released: the expected free counter value.
    int rnd_edges;
    always @(posedge clk) begin
        if (rst_rnd) rnd_edges <= 0;
        else         rnd_edges <= rnd_edges + 1;
    end

    int         n_tests, n_fail;
    logic [1:0] exp_tbl [16];
    logic [1:0] got_tbl [16];
    logic [1:0] g1_tbl  [16];
    int         hand6   [6] = '{0, 0, 0, 2, 3, 3};

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic build_model(input logic [15:0] seed);
        logic [15:0] l;
        l = (seed == 16'h0000) ? 16'hACE1 : seed;
        for (int i = 0; i < 16; i++) begin
            l = model_step(l);
            exp_tbl[i] = l[1:0];
        end
    endtask

    task automatic wait_edges(input int target);
        while (rnd_edges < target) tick();
        check("edge align", rnd_edges, target);
    endtask

    // Raise start on the selected DUT and check go/fill/ready timing.
    task automatic launch(input string tag, input bit from_ready);
        if (sel) start_rnd = 1'b1;
        else     start_fix = 1'b1;
        repeat (3) tick();
        if (from_ready) begin
            check({tag, " ready@E"}, int'(ready_s), 1);
            check({tag, " cn@E"}, int'(cn_s), int'(exp_tbl[seq]));
        end
        tick();
        check({tag, " ready@E+1"}, int'(ready_s), 0);
        check({tag, " cn@E+1"}, int'(cn_s), 0);
        repeat (15) tick();
        check({tag, " ready@E+16"}, int'(ready_s), 0);
        check({tag, " cn@E+16"}, int'(cn_s), 0);
        tick();
        check({tag, " ready@E+17"}, int'(ready_s), 1);
    endtask

    // Step sequence_count 0..15 then back to 0; each read lands one cycle later.
    task automatic sweep(input string tag);
        seq = 4'd0;
        for (int i = 0; i <= 16; i++) begin
            tick();
            check($sformatf("%s rd%0d", tag, i), int'(cn_s), int'(exp_tbl[i % 16]));
            if (i < 16) got_tbl[i] = cn_s;
            seq = 4'((i + 1) % 16);
        end
    endtask

    initial begin
        int diff;
        n_tests = 0; n_fail = 0;
        sel = 1'b0; seq = 4'd0;
        start_fix = 1'b0; start_rnd = 1'b0;
        rst_fix = 1'b1; rst_rnd = 1'b1;
        repeat (3) tick();
        check("reset ready", int'(ready_s), 0);
        check("reset cn", int'(cn_s), 0);
        rst_fix = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle ready", int'(ready_s), 0);
            check("idle cn", int'(cn_s), 0);
        end

        // Deterministic fill with the default seed.
        build_model(16'hACE1);
        launch("fix1", 1'b0);
        sweep("fix1");
        for (int i = 0; i < 6; i++) begin
            seq = 4'(i);
            tick();
            check($sformatf("hand rd%0d", i), int'(cn_s), hand6[i]);
        end

        // Reset in the middle of a refill.
        seq = 4'd3;
        tick();
        start_fix = 1'b0;
        repeat (5) tick();
        start_fix = 1'b1;
        repeat (3) tick();
        check("mid ready@E", int'(ready_s), 1);
        check("mid cn@E", int'(cn_s), 2);
        tick();
        check("mid ready@E+1", int'(ready_s), 0);
        check("mid cn@E+1", int'(cn_s), 0);
        repeat (7) tick();
        rst_fix = 1'b1;
        start_fix = 1'b0;
        tick();
        check("mid rst ready", int'(ready_s), 0);
        check("mid rst cn", int'(cn_s), 0);
        rst_fix = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post rst idle", int'(ready_s), 0);
        end
        launch("fix2", 1'b0);
        sweep("fix2");

        // Free-running seed: games at free_cnt 0x1234 and 0x5678.
        sel = 1'b1;
        rst_rnd = 1'b0;
        wait_edges(16'h1234 - 3);
        launch("g1", 1'b0);
        build_model(16'h1234);
        sweep("g1");
        for (int i = 0; i < 16; i++) g1_tbl[i] = got_tbl[i];
        seq = 4'd5;
        tick();
        start_rnd = 1'b0;
        wait_edges(16'h5678 - 3);
        launch("g2", 1'b1);
        build_model(16'h5678);
        sweep("g2");
        diff = 0;
        for (int i = 0; i < 16; i++) if (got_tbl[i] != g1_tbl[i]) diff++;
        check("tables differ", int'(diff != 0), 1);

        // Holding start high must not refill.
        for (int i = 0; i < 1000; i++) begin
            tick();
            check("hold ready", int'(ready_s), 1);
        end

        // go lands where free_cnt has wrapped to 0.
        seq = 4'd2;
        tick();
        start_rnd = 1'b0;
        wait_edges(65536 - 3);
        launch("zero", 1'b1);
        build_model(16'h0000);
        sweep("zero");
        diff = 0;
        for (int i = 0; i < 16; i++) if (got_tbl[i] != 2'd0) diff++;
        check("zero not stuck", int'(diff != 0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
